// File: rtl/obi_mem_pkg.sv
// Shared types and constants for the OBI memory responder: response beat layout,
// bus widths and the wait-state LFSR definition.
package obi_mem_pkg;

   localparam int OBI_ADDR_W = 32;
   localparam int OBI_DATA_W = 32;
   localparam int OBI_INTG_W = 7;

   // Fibonacci LFSR, taps 16,14,13,11 -> state bits 15,13,12,10
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef struct packed {
      logic                  valid;
      logic [OBI_DATA_W-1:0] rdata;
      logic                  err;
   } resp_t;

   function automatic logic [15:0] lfsr_next(input logic [15:0] state);
      return {state[14:0], ^(state & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/obi_resp_pipe.sv
// Fixed-latency response delay line: LATENCY stages of resp_t, stage 0 loads every
// cycle and the last stage is presented directly as registered outputs.
module obi_resp_pipe
   import obi_mem_pkg::*;
#(
   parameter int unsigned LATENCY = 1
) (
   input  logic  CLK,
   input  logic  RST,
   input  resp_t i_resp,
   output resp_t o_resp
);

   resp_t r_stage    [LATENCY];
   resp_t w_stage_in [LATENCY];

   assign w_stage_in[0] = i_resp;

   for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
      if (gi > 0) begin : g_link
         assign w_stage_in[gi] = r_stage[gi-1];
      end

      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            r_stage[gi] <= '0;
         end else begin
            r_stage[gi] <= w_stage_in[gi];
         end
      end
   end

   assign o_resp = r_stage[LATENCY-1];

endmodule

// File: rtl/obi_mem_responder.sv
// OBI memory target: word RAM with byte-enable writes, fixed response latency and a
// bounded number of outstanding requests. Define MEM_RESP_RAND_STALL_EN for LFSR wait states.
module obi_mem_responder
   import obi_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS     = 1024,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int unsigned LATENCY         = 1,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  req_i,
   output logic                  gnt_o,
   input  logic [OBI_ADDR_W-1:0] addr_i,
   input  logic                  we_i,
   input  logic [3:0]            be_i,
   input  logic [OBI_DATA_W-1:0] wdata_i,
   input  logic [OBI_INTG_W-1:0] wdata_intg_i,
   output logic                  rvalid_o,
   output logic [OBI_DATA_W-1:0] rdata_o,
   output logic [OBI_INTG_W-1:0] rdata_intg_o,
   output logic                  err_o
);

   localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int          CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [32:0] SPAN  = 33'(4 * DEPTH_WORDS);

   logic [OBI_DATA_W-1:0] r_mem [DEPTH_WORDS];
   logic [CNT_W-1:0]      r_outstanding;
   logic [32:0]           w_offset;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_err;
   logic                  w_accept;
   logic                  w_slot_free;
   logic                  w_stall_n;
   logic                  w_unused;
   resp_t                 w_resp_in;
   resp_t                 w_resp;

   // 33-bit offset: a borrow (address below base) lands above SPAN and reads as out of range
   assign w_offset = {1'b0, addr_i} - {1'b0, BASE_ADDR};
   assign w_idx    = w_offset[IDX_W+1:2];
   assign w_err    = (addr_i[1:0] != 2'b00) || (w_offset >= SPAN);
   assign w_unused = ^{wdata_intg_i, w_offset[32:IDX_W+2], w_offset[1:0]};

`ifdef MEM_RESP_RAND_STALL_EN
   logic [15:0] r_lfsr;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= lfsr_next(r_lfsr);
      end
   end

   assign w_stall_n = (r_lfsr[1:0] != 2'b00);
`else
   assign w_stall_n = 1'b1;
`endif

   // The response on the bus this cycle retires its slot, so a full counter can still grant
   assign w_slot_free = (r_outstanding < CNT_W'(MAX_OUTSTANDING)) || w_resp.valid;
   assign gnt_o       = req_i && w_slot_free && w_stall_n;
   assign w_accept    = req_i && gnt_o;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_outstanding <= '0;
      end else if (w_accept && !w_resp.valid) begin
         r_outstanding <= r_outstanding + CNT_W'(1);
      end else if (!w_accept && w_resp.valid) begin
         r_outstanding <= r_outstanding - CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (w_accept && we_i && !w_err) begin
         for (int n = 0; n < 4; n++) begin
            if (be_i[n]) begin
               r_mem[w_idx][8*n +: 8] <= wdata_i[8*n +: 8];
            end
         end
      end
   end

   always_comb begin
      w_resp_in       = '0;
      w_resp_in.valid = w_accept;
      w_resp_in.err   = w_accept && w_err;
      if (w_accept && !w_err && !we_i) begin
         w_resp_in.rdata = r_mem[w_idx];
      end
   end

   obi_resp_pipe #(
      .LATENCY (LATENCY)
   ) u_resp_pipe (
      .CLK    (CLK),
      .RST    (RST),
      .i_resp (w_resp_in),
      .o_resp (w_resp)
   );

   assign rvalid_o     = w_resp.valid;
   assign rdata_o      = w_resp.rdata;
   assign err_o        = w_resp.err;
   assign rdata_intg_o = '0;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: three configurations checked every cycle against a
// queue-based reference model, plus directed literal checks. Honours MEM_RESP_RAND_STALL_EN.
`timescale 1ns/1ps
module tb_obi_mem_responder;

   localparam int N     = 3;
   localparam int DEPTH = 64;

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic int max_of(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 2 : 3);
   endfunction

   function automatic logic [31:0] base_of(input int d);
      return (d == 2) ? 32'h0000_1000 : 32'h0000_0000;
   endfunction

   logic        CLK = 1'b0;
   logic        RST;
   logic        req    [N];
   logic        gnt    [N];
   logic [31:0] addr   [N];
   logic        we     [N];
   logic [3:0]  be     [N];
   logic [31:0] wdata  [N];
   logic        rvalid [N];
   logic [31:0] rdata  [N];
   logic [6:0]  rintg  [N];
   logic        err    [N];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      obi_mem_responder #(
         .DEPTH_WORDS     (DEPTH),
         .BASE_ADDR       (base_of(gi)),
         .LATENCY         (lat_of(gi)),
         .MAX_OUTSTANDING (max_of(gi))
      ) u_dut (
         .CLK          (CLK),
         .RST          (RST),
         .req_i        (req[gi]),
         .gnt_o        (gnt[gi]),
         .addr_i       (addr[gi]),
         .we_i         (we[gi]),
         .be_i         (be[gi]),
         .wdata_i      (wdata[gi]),
         .wdata_intg_i (7'h55),
         .rvalid_o     (rvalid[gi]),
         .rdata_o      (rdata[gi]),
         .rdata_intg_o (rintg[gi]),
         .err_o        (err[gi])
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, required %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] due;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        q     [N][$];
   logic [31:0] mem_m [N][DEPTH];

`ifdef MEM_RESP_RAND_STALL_EN
   logic [15:0] lfsr_m = 16'hACE1;
`endif

   task automatic model_accept(input int d);
      longint a, base;
      int     idx;
      exp_t   e;
      a      = 64'(addr[d]);
      base   = 64'(base_of(d));
      e.due  = 32'(cyc + lat_of(d));
      e.data = 32'h0;
      e.err  = 1'b0;
      if ((a % 4) != 0 || a < base || a >= base + 4 * DEPTH) begin
         e.err = 1'b1;
      end else begin
         idx = int'((a - base) / 4);
         if (we[d]) begin
            for (int n = 0; n < 4; n++)
               if (be[d][n]) mem_m[d][idx][8*n +: 8] = wdata[d][8*n +: 8];
         end else begin
            e.data = mem_m[d][idx];
         end
      end
      q[d].push_back(e);
   endtask

   always @(negedge CLK) begin
      logic stall, due_now, exp_gnt;
      int   busy;
      stall = 1'b0;
`ifdef MEM_RESP_RAND_STALL_EN
      stall = (lfsr_m[1:0] == 2'b00);
`endif
      for (int d = 0; d < N; d++) begin
         if (RST) begin
            chk($sformatf("rst_rvalid[%0d]", d), 32'(rvalid[d]), 32'h0);
            chk($sformatf("rst_rdata[%0d]", d), rdata[d], 32'h0);
            chk($sformatf("rst_err[%0d]", d), 32'(err[d]), 32'h0);
            q[d].delete();
         end else begin
            due_now = (q[d].size() > 0) && (q[d][0].due == 32'(cyc));
            chk($sformatf("rvalid[%0d]", d), 32'(rvalid[d]), 32'(due_now));
            if (due_now) begin
               chk($sformatf("rdata[%0d]", d), rdata[d], q[d][0].data);
               chk($sformatf("err[%0d]", d), 32'(err[d]), 32'(q[d][0].err));
               chk($sformatf("rintg[%0d]", d), 32'(rintg[d]), 32'h0);
               $display("inst%0d cyc %0d resp rdata=%08h err=%0b", d, cyc, rdata[d], err[d]);
               void'(q[d].pop_front());
            end
            busy    = q[d].size();
            exp_gnt = req[d] && (busy < max_of(d)) && !stall;
            chk($sformatf("gnt[%0d]", d), 32'(gnt[d]), 32'(exp_gnt));
            if (exp_gnt) model_accept(d);
         end
      end
`ifdef MEM_RESP_RAND_STALL_EN
      lfsr_m = RST ? 16'hACE1 : {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`endif
   end

   // ---------------- stimulus ----------------
   task automatic do_req(input int d, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] wd);
      int waited;
      waited   = 0;
      req[d]   = 1'b1;
      we[d]    = w;
      addr[d]  = a;
      be[d]    = b;
      wdata[d] = wd;
      while (1) begin
         @(negedge CLK);
         if (gnt[d]) break;
         waited++;
         if (waited > 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL gnt_timeout[%0d]: no grant in 50 cycles, required a grant", d);
            break;
         end
      end
      @(posedge CLK);
      #1;
      req[d] = 1'b0;
   endtask

   // Called right after the accepting edge with nothing else in flight.
   task automatic wait_resp(input int d, input string name, input logic [31:0] exp_d,
                            input logic exp_e);
      int k;
      k = 0;
      while (k < 10) begin
         @(negedge CLK);
         if (rvalid[d]) break;
         k++;
      end
      chk({name, "_latency"}, 32'(k), 32'(lat_of(d) - 1));
      chk({name, "_rvalid"}, 32'(rvalid[d]), 32'h1);
      chk({name, "_rdata"}, rdata[d], exp_d);
      chk({name, "_err"}, 32'(err[d]), 32'(exp_e));
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic fill(input int d);
      for (int i = 0; i < DEPTH; i++)
         do_req(d, 1'b1, base_of(d) + 32'(4 * i), 4'hF, $urandom);
   endtask

   task automatic rand_run(input int d);
      for (int i = 0; i < 200; i++) begin
         int          sel;
         logic [31:0] a;
         sel = int'($urandom_range(0, 9));
         a   = base_of(d) + 32'(4 * $urandom_range(0, DEPTH - 1));
         if (sel == 0)      a = a + 32'($urandom_range(1, 3));
         else if (sel == 1) a = base_of(d) + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
         else if (sel == 2) a = base_of(d) - 32'h4;
         do_req(d, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
   endtask

   logic [4:0] gnt_pat;
   logic [7:0] rv_pat;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1;
      for (int d = 0; d < N; d++) begin
         req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; be[d] = '0; wdata[d] = '0;
      end
      @(posedge CLK);
      @(posedge CLK);
      #1;
      RST = 1'b0;

      fork
         fill(0);
         fill(1);
         fill(2);
      join
      idle(6);

      // write then read, LATENCY=1
      do_req(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
      do_req(0, 1'b0, 32'h10, 4'hF, 32'h0);
      wait_resp(0, "raw", 32'hDEAD_BEEF, 1'b0);

      // byte enables and a be=0 no-op write
      do_req(0, 1'b1, 32'h20, 4'hF, 32'h1122_3344);
      do_req(0, 1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD);
      do_req(0, 1'b0, 32'h20, 4'h0, 32'h0);
      wait_resp(0, "be", 32'h11BB_33DD, 1'b0);
      do_req(0, 1'b1, 32'h20, 4'h0, 32'hFFFF_FFFF);
      wait_resp(0, "be0_wr", 32'h0, 1'b0);
      do_req(0, 1'b0, 32'h20, 4'hF, 32'h0);
      wait_resp(0, "be0_rd", 32'h11BB_33DD, 1'b0);

      // address errors leave storage intact
      do_req(0, 1'b1, 32'hFC, 4'hF, 32'hCAFE_F00D);
      do_req(0, 1'b1, 32'h00, 4'hF, 32'h0123_4567);
      do_req(0, 1'b0, 32'h02, 4'hF, 32'h0);
      wait_resp(0, "err_misalign", 32'h0, 1'b1);
      do_req(0, 1'b1, 32'(4 * DEPTH), 4'hF, 32'hFFFF_FFFF);
      wait_resp(0, "err_range", 32'h0, 1'b1);
      do_req(0, 1'b0, 32'hFC, 4'hF, 32'h0);
      wait_resp(0, "keep_last", 32'hCAFE_F00D, 1'b0);
      do_req(0, 1'b0, 32'h00, 4'hF, 32'h0);
      wait_resp(0, "keep_first", 32'h0123_4567, 1'b0);

      // reset mid-read discards the response
      do_req(0, 1'b1, 32'h40, 4'hF, 32'h5A5A_1234);
      do_req(0, 1'b0, 32'h40, 4'hF, 32'h0);
      RST = 1'b1;
      #1;
      chk("rst_now_rvalid", 32'(rvalid[0]), 32'h0);
      chk("rst_now_rdata", rdata[0], 32'h0);
      chk("rst_now_err", 32'(err[0]), 32'h0);
      @(posedge CLK);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h40; be[0] = 4'hF;
      @(negedge CLK);
      chk("post_rst_gnt", 32'(gnt[0]), 32'h1);
      @(posedge CLK);
      #1;
      req[0] = 1'b0;
      wait_resp(0, "post_rst", 32'h5A5A_1234, 1'b0);
      idle(3);

      // throughput, LATENCY=3: MAX_OUTSTANDING=2 then 3
      fork
         for (int i = 0; i < 4; i++) do_req(1, 1'b0, 32'(4 * i), 4'hF, 32'h0);
         for (int i = 0; i < 5; i++) begin @(negedge CLK); gnt_pat[i] = gnt[1]; end
      join
      idle(8);
      fork
         for (int i = 0; i < 4; i++) do_req(2, 1'b0, base_of(2) + 32'(4 * i), 4'hF, 32'h0);
         for (int i = 0; i < 8; i++) begin @(negedge CLK); rv_pat[i] = rvalid[2]; end
      join
`ifndef MEM_RESP_RAND_STALL_EN
      chk("gnt_pattern_m2", 32'(gnt_pat), 32'b11011);
      chk("rvalid_pattern_m3", 32'(rv_pat), 32'b0111_1000);
`endif
      idle(8);

      fork
         rand_run(0);
         rand_run(1);
         rand_run(2);
      join
      idle(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
